// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged 2-bit counters, zero-latency lookup.
// Define BP_STATS_EN to add branch_count / mispredict_count outputs.
module branch_predictor #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
`ifdef BP_STATS_EN
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
`endif
  output logic        mispredict
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  logic              tbl_valid [DEPTH];
  logic [TAG_W-1:0]  tbl_tag   [DEPTH];
  logic [29:0]       tbl_tgt   [DEPTH];
  logic [1:0]        tbl_cnt   [DEPTH];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_hit;

  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_hit;
  logic                  upd;
  logic [1:0]            cnt_nxt;

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_target[1:0]};

  assign rd_idx = if_pc[INDEX_BITS+1:2];
  assign rd_tag = if_pc[31:INDEX_BITS+2];
  assign rd_hit = tbl_valid[rd_idx] && (tbl_tag[rd_idx] == rd_tag);

  assign pred_taken  = rd_hit && tbl_cnt[rd_idx][1];
  assign pred_target = pred_taken ? {tbl_tgt[rd_idx], 2'b00} : 32'h0;

  assign upd    = ex_valid && ex_is_branch;
  assign wr_idx = ex_pc[INDEX_BITS+1:2];
  assign wr_tag = ex_pc[31:INDEX_BITS+2];
  assign wr_hit = tbl_valid[wr_idx] && (tbl_tag[wr_idx] == wr_tag);

  assign mispredict = upd &&
    ((ex_taken != ex_pred_taken) ||
     (ex_taken && (ex_pred_target != ex_target)));

  always_comb begin
    cnt_nxt = tbl_cnt[wr_idx];
    if (ex_taken) begin
      if (tbl_cnt[wr_idx] != 2'b11)
        cnt_nxt = tbl_cnt[wr_idx] + 2'b01;
    end else begin
      if (tbl_cnt[wr_idx] != 2'b00)
        cnt_nxt = tbl_cnt[wr_idx] - 2'b01;
    end
  end

  // Tags and targets are left unreset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_cnt[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (wr_hit) begin
        tbl_cnt[wr_idx] <= cnt_nxt;
        if (ex_taken)
          tbl_tgt[wr_idx] <= ex_target[31:2];
      end else if (ex_taken) begin
        tbl_valid[wr_idx] <= 1'b1;
        tbl_tag[wr_idx]   <= wr_tag;
        tbl_tgt[wr_idx]   <= ex_target[31:2];
        tbl_cnt[wr_idx]   <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else begin
      if (upd && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'h1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'h1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 5, number of index bits; table depth is 2^INDEX_BITS entries.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port if_pc  in  32  fetch-stage PC to look up.
REQ-005 Port pred_taken  out  1  predict taken for if_pc; feeds the IF pc_mux select when the IF use_predictor control bit is set.
REQ-006 Port pred_target  out  32  predicted target for if_pc; 0 when pred_taken=0.
REQ-007 Port ex_valid  in  1  EX-stage instruction valid (not bubble, not flushed).
REQ-008 Port ex_is_branch  in  1  EX instruction is a conditional branch (BRANCH opcode).
REQ-009 Port ex_pc  in  32  PC of the EX instruction.
REQ-010 Port ex_taken  in  1  resolved branch outcome (cmp result).
REQ-011 Port ex_target  in  32  resolved branch target.
REQ-012 Port ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-013 Port ex_pred_target  in  32  predicted target carried down the pipe.
REQ-014 Port mispredict  out  1  combinational; EX branch was mispredicted, pipeline redirect required.

Function
REQ-015 Table entry fields: valid (1), tag (32-2-INDEX_BITS bits, pc[31:INDEX_BITS+2]), target (30 bits, pc[31:2]), counter (2-bit saturating).
REQ-016 Index = pc[INDEX_BITS+1:2]; pc[1:0] ignored for index, tag, and target storage; stored target is reconstructed with low bits 00.
REQ-017 Lookup is combinational, zero latency: hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = {target,2'b00} when pred_taken, else 0.
REQ-018 Update occurs only when ex_valid && ex_is_branch; written at the next rising edge; one update per cycle max.
REQ-019 Update on hit: counter increments if ex_taken (saturating at 11), decrements if not (saturating at 00); target overwritten with ex_target[31:2] when ex_taken.
REQ-020 Update on miss, ex_taken=1: allocate entry (valid=1, tag, target=ex_target[31:2], counter=10), replacing any existing occupant.
REQ-021 Update on miss, ex_taken=0: no table change.
REQ-022 mispredict = ex_valid && ex_is_branch && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)); 0 otherwise.
REQ-023 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass); the update is visible from the following cycle.
REQ-024 ex_valid=0 or ex_is_branch=0: table unchanged, mispredict=0, regardless of other ex_* values.

Reset
REQ-025 While rst=1 at a rising edge: all valid bits cleared, all counters set to 01; tags and targets don't care; any concurrent update is discarded.
REQ-026 After reset, every lookup returns pred_taken=0, pred_target=0 until an allocation occurs.
REQ-027 Reset mid-operation behaves identically to power-on reset; no partial updates survive.

Configuration
REQ-028 Macro BP_STATS_EN: when defined, adds outputs branch_count (32) and mispredict_count (32).
REQ-029 branch_count increments per qualifying update (REQ-018); mispredict_count increments whenever mispredict=1; both saturate at 0xFFFFFFFF; both cleared by rst.
REQ-030 Without BP_STATS_EN: counter ports and logic absent; predictor behaviour is otherwise identical.

Verification
REQ-031 Reset, then if_pc=0x60000010 -> pred_taken=0, pred_target=0.
REQ-032 Update ex_pc=0x60000010, taken, ex_target=0x60000100, ex_pred_taken=0 -> mispredict=1 that cycle; next cycle, lookup of 0x60000010 -> pred_taken=1, pred_target=0x60000100.
REQ-033 Three not-taken updates at 0x60000010 after REQ-032 -> counter 10->01->00->00; pred_taken=0 after the first, saturated at 00 after the third.
REQ-034 Alias: update taken at 0x60000090 (same index, INDEX_BITS=5) -> replaces entry; lookup of 0x60000010 -> miss, pred_taken=0.
REQ-035 Same-cycle update (taken) and lookup at the same index with valid entry counter=01 -> pred_taken=0 that cycle, 1 next cycle.
REQ-036 With BP_STATS_EN: 10 branches, 3 mispredicted, then rst -> counts 10/3 before reset, 0/0 after.
